// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//  Shared definitions for the instruction-fetch slice: reset PC default,
//  NOP encoding, PC step, the {pc, inst} entry carried by the skid buffer,
//  and a helper that word-aligns a byte PC.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered fetch result; pc sits in the upper half of the 64-bit word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;

  // Redirect targets may be misaligned; the low two bits are simply dropped
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//  Bundles the instruction-memory port, the redirect request from execute
//  and the valid/ready instruction handshake towards decode.
//  master : the fetch unit (drives imem_addr and the instruction outputs)
//  slave  : the environment (memory, execute and decode)
//  Signals:
//   imem_addr   word address to the memory (ADDR_BITS wide)
//   imem_data   memory read data, valid one cycle after the address
//   redirect    one-cycle pulse to restart fetch at redirect_pc
//   redirect_pc byte target of the redirect
//   inst_valid  inst_out/inst_pc hold a valid instruction
//   inst_ready  decode accepts the instruction this cycle
//   inst_out    instruction word
//   inst_pc     byte PC of inst_out
interface fetch_unit_if #(
  parameter int ADDR_BITS = 32
);

  logic [ADDR_BITS-1:0] imem_addr;
  logic [31:0]          imem_data;
  logic                 redirect;
  logic [31:0]          redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst_out;
  logic [31:0]          inst_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_unit_skid_buffer.sv
// fetch_skid_buffer
//  Small circular FIFO holding fetched {pc, inst} entries between the
//  memory response and decode. Head/tail pointers wrap modulo DEPTH.
//  Ports:
//   clk, rst  clock and synchronous active-high reset
//   i_push    write i_data at the tail
//   i_data    entry to write
//   i_pop     drop the head entry
//   i_flush   empty the FIFO (dominates push and pop)
//   o_count   number of valid entries
//   o_head    entry at the head (meaningful only when o_count != 0)
module fetch_skid_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Explicit wrap so non-power-of-two depths would still work
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; push+pop together keeps the count
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= nextPtr(r_tail);
      end
      if (i_pop) begin
        r_head <= nextPtr(r_head);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; stale slots are never visible while count is 0
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !rst) begin
      r_mem[r_tail] <= i_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//  Instruction-fetch stage. Owns the PC, drives the word address of a
//  memory with a one-cycle registered read, parks returned words in a skid
//  buffer and hands {pc, instruction} to decode over valid/ready.
//  Redirects from execute flush buffered and in-flight fetches.
//  Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fetch_unit_if.master (memory port, redirect, decode handshake)
//  Parameters:
//   RESET_PC   first byte PC fetched after reset
//   ADDR_BITS  memory word-address width
//   BUF_DEPTH  skid-buffer entries (2 or 4)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          ADDR_BITS = 32,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      r_pc;
  logic [31:0]      r_reqPc;
  logic             r_inflight;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_valid;
  logic             w_deq;
  logic             w_issue;
  logic             w_push;
  logic [31:0]      w_issuePc;
  logic [31:0]      w_wordAddr;
  fetchEntry_t      w_pushEntry;
  fetchEntry_t      w_head;

  assign w_valid = (w_count != '0);
  assign w_deq   = w_valid & bus.inst_ready;

  // A redirect fetches its target this very cycle, bypassing pc_q
  assign w_issuePc     = bus.redirect ? alignPc(bus.redirect_pc) : r_pc;
  assign w_wordAddr    = {2'b00, w_issuePc[31:2]};
  assign bus.imem_addr = w_wordAddr[ADDR_BITS-1:0];

  // Only issue when the response is guaranteed a free buffer slot
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_deq};
  assign w_issue     = bus.redirect || (w_occupancy < (CNT_W + 1)'(BUF_DEPTH));

  // The response landing in a redirect cycle belongs to the old stream
  assign w_push      = r_inflight & ~bus.redirect;
  assign w_pushEntry = '{pc: r_reqPc, inst: bus.imem_data};

  // PC, in-flight flag and the PC tag of the outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_reqPc    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_reqPc <= w_issuePc;
        r_pc    <= w_issuePc + PC_STEP;
      end
    end
  end

  fetch_skid_buffer #(
    .WIDTH ($bits(fetchEntry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_pushEntry),
    .i_pop   (w_deq),
    .i_flush (bus.redirect),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Outputs read as zero whenever nothing valid is buffered
  assign bus.inst_valid = w_valid;
  assign bus.inst_out   = w_valid ? w_head.inst : '0;
  assign bus.inst_pc    = w_valid ? w_head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//  Directed bench for fetch_unit. Memory model: word i holds
//  32'h1000_0000 + i with a one-cycle registered read. A depth-4 instance
//  at PC 0 exercises streaming, backpressure, redirects and reset; a
//  depth-2 instance at 32'hFFFF_FFF8 with a 30-bit address checks wrap.
//  Inputs change on the falling edge; outputs are sampled there too.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_BITS(32)) mainIf ();
  fetch_unit_if #(.ADDR_BITS(30)) wrapIf ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_BITS (32),
    .BUF_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mainIf)
  );

  fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .ADDR_BITS (30),
    .BUF_DEPTH (2)
  ) dutWrap (
    .clk (clk),
    .rst (rst),
    .bus (wrapIf)
  );

  // Registered-read memory models for both instances
  always @(posedge clk) begin
    mainIf.imem_data <= 32'h1000_0000 + mainIf.imem_addr;
    wrapIf.imem_data <= 32'h1000_0000 + {2'b00, wrapIf.imem_addr};
  end

  // Single comparison point: counts every check, reports each mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input logic r, input logic rdy, input logic redir,
                             input logic [31:0] rpc);
    rst                = r;
    mainIf.inst_ready  = rdy;
    mainIf.redirect    = redir;
    mainIf.redirect_pc = rpc;
  endtask

  // Hold the given inputs across one rising edge, return at the falling edge
  task automatic applyStimulus(input logic r, input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    driveInputs(r, rdy, redir, rpc);
    @(negedge clk);
  endtask

  task automatic expectInst(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(mainIf.inst_valid), 32'd1);
    checkOutput({tag, "_pc"},    mainIf.inst_pc,  pc);
    checkOutput({tag, "_inst"},  mainIf.inst_out, 32'h1000_0000 + (pc >> 2));
  endtask

  task automatic expectWrap(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(wrapIf.inst_valid), 32'd1);
    checkOutput({tag, "_pc"},    wrapIf.inst_pc,  pc);
    checkOutput({tag, "_inst"},  wrapIf.inst_out, 32'h1000_0000 + (pc >> 2));
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(mainIf.inst_valid), 32'd0);
  endtask

  initial begin
    wrapIf.inst_ready  = 1'b1;
    wrapIf.redirect    = 1'b0;
    wrapIf.redirect_pc = 32'h0;
    driveInputs(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // Reset state
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    expectIdle("rst");
    checkOutput("rst_inst", mainIf.inst_out, 32'h0);
    checkOutput("rst_pc", mainIf.inst_pc, 32'h0);
    checkOutput("rst_addr", mainIf.imem_addr, 32'h0);
    checkOutput("rst_count", 32'(dut.u_buffer.r_count), 32'd0);
    checkOutput("rst_wrapAddr", 32'(wrapIf.imem_addr), 32'h3FFF_FFFE);

    // Streaming: first edge issues pc 0, valid one cycle later
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectIdle("lat");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("s0", 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("s4", 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("s8", 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("s12", 32'hC);

    // One stall cycle: pc 12 held, pc 16 buffered behind it, pc 20 in flight
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    expectInst("hold12", 32'hC);
    checkOutput("pre_redir_count", 32'(dut.u_buffer.r_count), 32'd2);

    // Redirect to 0x40: target address driven combinationally this cycle
    driveInputs(1'b0, 1'b0, 1'b1, 32'h40);
    #1 checkOutput("redir_addr", mainIf.imem_addr, 32'h10);
    @(negedge clk);
    expectIdle("redir_flush");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r40", 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r44", 32'h44);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r48", 32'h48);

    // Build two buffered entries, then redirect to 0x23 while 0x48 dequeues
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    expectInst("hold48", 32'h48);
    driveInputs(1'b0, 1'b1, 1'b1, 32'h23);
    #1 checkOutput("misalign_addr", mainIf.imem_addr, 32'h8);
    @(negedge clk);
    expectIdle("deq_redir");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r20", 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r24", 32'h24);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("r28", 32'h28);

    // Backpressure: six stalled cycles, head stays 0x28, buffer fills to 4
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      expectInst($sformatf("stall%0d", i), 32'h28);
    end
    checkOutput("full_count", 32'(dut.u_buffer.r_count), 32'd4);
    checkOutput("full_inflight", 32'(dut.r_inflight), 32'd0);
    checkOutput("stall_addr", mainIf.imem_addr, 32'hE);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      expectInst($sformatf("resume%0d", i), 32'h2C + 32'(4 * i));
    end

    // Reset with a simultaneous redirect: reset wins, restart at RESET_PC
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    expectIdle("rst2");
    checkOutput("rst2_pc", mainIf.inst_pc, 32'h0);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h0);
    #1 checkOutput("rst2_addr", mainIf.imem_addr, 32'h0);
    checkOutput("rst2_wrapAddr", 32'(wrapIf.imem_addr), 32'h3FFF_FFFE);
    @(negedge clk);
    expectIdle("rst2_lat");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("re0", 32'h0);
    expectWrap("wF8", 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("re4", 32'h4);
    expectWrap("wFC", 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectInst("re8", 32'h8);
    expectWrap("w00", 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
